// File: rtl/regjistrat_8x16_pkg.sv
// Shared constants for the 8x16 operand register file: default widths,
// the hardwired-zero register index and symbolic register names.
package regjistrat_8x16_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;

    localparam int REG_ZERO = 0;

    localparam logic [ADDR_W_DEF-1:0] R0 = 3'd0;
    localparam logic [ADDR_W_DEF-1:0] R1 = 3'd1;
    localparam logic [ADDR_W_DEF-1:0] R2 = 3'd2;
    localparam logic [ADDR_W_DEF-1:0] R3 = 3'd3;
    localparam logic [ADDR_W_DEF-1:0] R4 = 3'd4;
    localparam logic [ADDR_W_DEF-1:0] R5 = 3'd5;
    localparam logic [ADDR_W_DEF-1:0] R6 = 3'd6;
    localparam logic [ADDR_W_DEF-1:0] R7 = 3'd7;

    typedef logic [DATA_W_DEF-1:0] word_t;

endpackage

// File: rtl/regjistrat_lexo.sv
// One combinational read port: register select, optional write-data bypass,
// and forced zero for R0 and while reset is asserted.
module regjistrat_lexo
    import regjistrat_8x16_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BYPASS = 1
) (
    input  logic                                 Reset_n,
    input  logic [ADDR_W-1:0]                    addr,
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]   regs,
    input  logic                                 wr_en,
    input  logic [ADDR_W-1:0]                    wr_addr,
    input  logic [DATA_W-1:0]                    wr_data,
    output logic [DATA_W-1:0]                    data
);

    always_comb begin
        data = regs[addr];
        if ((BYPASS != 0) && wr_en && (addr == wr_addr)) begin
            data = wr_data;
        end
        // Reset and R0 override everything, including a bypass hit.
        if (!Reset_n || (addr == ADDR_W'(REG_ZERO))) begin
            data = '0;
        end
    end

endmodule

// File: rtl/regjistrat_8x16.sv
// Eight-entry operand register file for the single-cycle datapath:
// one synchronous write port, two combinational read ports, R0 reads as zero.
module regjistrat_8x16
    import regjistrat_8x16_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BYPASS = 1
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteAddr,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadAddr1,
    input  logic [ADDR_W-1:0] ReadAddr2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);

    localparam int NREG = 2**ADDR_W;

    logic [DATA_W-1:0]             mem_q [1:NREG-1];
    logic [NREG-1:0][DATA_W-1:0]   regs_view;
    logic                          wr_en;

    // An unknown address makes wr_en unknown, which the if below treats as false.
    assign wr_en = RegWrite && (WriteAddr != ADDR_W'(R0));

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 1; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 1; i < NREG; i++) begin
                if (WriteAddr == ADDR_W'(i)) begin
                    mem_q[i] <= WriteData;
                end
            end
        end
    end

    always_comb begin
        regs_view = '0;
        for (int i = 1; i < NREG; i++) begin
            regs_view[i] = mem_q[i];
        end
    end

    regjistrat_lexo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_lexo1 (
        .Reset_n (Reset_n),
        .addr    (ReadAddr1),
        .regs    (regs_view),
        .wr_en   (wr_en),
        .wr_addr (WriteAddr),
        .wr_data (WriteData),
        .data    (ReadData1)
    );

    regjistrat_lexo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_lexo2 (
        .Reset_n (Reset_n),
        .addr    (ReadAddr2),
        .regs    (regs_view),
        .wr_en   (wr_en),
        .wr_addr (WriteAddr),
        .wr_data (WriteData),
        .data    (ReadData2)
    );

endmodule

// File: tb/tb_regjistrat_8x16.sv
// Scoreboard bench: two instances (bypass on/off) share stimulus; expected
// read data is queued by the stimulus and checked by a separate monitor.
module tb_regjistrat_8x16;
    import regjistrat_8x16_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b1;
    logic        RegWrite = 1'b0;
    logic [2:0]  WriteAddr = '0;
    logic [15:0] WriteData = '0;
    logic [2:0]  ReadAddr1 = '0;
    logic [2:0]  ReadAddr2 = '0;
    logic [15:0] rd1_b, rd2_b, rd1_n, rd2_n;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string       name;
        bit          byp;
        logic [15:0] e1;
        logic [15:0] e2;
    } exp_t;

    exp_t exp_q[$];
    event chk_ev;

    always #5 Clock = ~Clock;

    regjistrat_8x16 #(.DATA_W(16), .ADDR_W(3), .BYPASS(1)) u_byp (
        .Clock(Clock), .Reset_n(Reset_n), .RegWrite(RegWrite),
        .WriteAddr(WriteAddr), .WriteData(WriteData),
        .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2),
        .ReadData1(rd1_b), .ReadData2(rd2_b)
    );

    regjistrat_8x16 #(.DATA_W(16), .ADDR_W(3), .BYPASS(0)) u_nob (
        .Clock(Clock), .Reset_n(Reset_n), .RegWrite(RegWrite),
        .WriteAddr(WriteAddr), .WriteData(WriteData),
        .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2),
        .ReadData1(rd1_n), .ReadData2(rd2_n)
    );

    // Monitor: pops expectations and compares against the selected instance.
    initial begin
        exp_t        e;
        logic [15:0] a1, a2;
        forever begin
            @(chk_ev);
            while (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                a1 = e.byp ? rd1_b : rd1_n;
                a2 = e.byp ? rd2_b : rd2_n;
                n_checks++;
                if (a1 === e.e1) n_pass++;
                else $display("FAIL %s byp=%0d rd1 got %h want %h", e.name, e.byp, a1, e.e1);
                n_checks++;
                if (a2 === e.e2) n_pass++;
                else $display("FAIL %s byp=%0d rd2 got %h want %h", e.name, e.byp, a2, e.e2);
            end
        end
    end

    task automatic expect1(input string name, input bit byp,
                           input logic [15:0] e1, input logic [15:0] e2);
        exp_t e;
        e.name = name; e.byp = byp; e.e1 = e1; e.e2 = e2;
        exp_q.push_back(e);
    endtask

    // Settle, queue expectations for both instances, let the monitor run.
    task automatic chk(input string name, input logic [15:0] b1, input logic [15:0] b2,
                       input logic [15:0] n1, input logic [15:0] n2);
        #1;
        expect1(name, 1'b1, b1, b2);
        expect1(name, 1'b0, n1, n2);
        -> chk_ev;
        #1;
    endtask

    task automatic drive(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                         input logic [2:0] ra1, input logic [2:0] ra2);
        @(negedge Clock);
        RegWrite  = we;
        WriteAddr = wa;
        WriteData = wd;
        ReadAddr1 = ra1;
        ReadAddr2 = ra2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout got running want finished");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] vk, vm;

        // Reset clears immediately, before any clock edge, and ignores writes.
        #1;
        Reset_n = 1'b0;
        RegWrite = 1'b1; WriteAddr = R3; WriteData = 16'hBEEF;
        ReadAddr1 = R3; ReadAddr2 = R3;
        chk("rst_noclk", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        repeat (2) @(posedge Clock);
        chk("rst_hold", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        @(negedge Clock);
        Reset_n = 1'b1;
        RegWrite = 1'b0;
        chk("rst_release", 16'h0000, 16'h0000, 16'h0000, 16'h0000);

        // Basic write/read of R5.
        drive(1'b1, R5, 16'h1234, R5, R5);
        chk("r5_same", 16'h1234, 16'h1234, 16'h0000, 16'h0000);
        drive(1'b0, R5, 16'h0000, R5, R5);
        chk("r5_read", 16'h1234, 16'h1234, 16'h1234, 16'h1234);
        ReadAddr1 = R1; ReadAddr2 = R7;
        chk("others_zero", 16'h0000, 16'h0000, 16'h0000, 16'h0000);

        // R0 protection, with and without bypass.
        drive(1'b1, R0, 16'hFFFF, R0, R5);
        chk("r0_same", 16'h0000, 16'h1234, 16'h0000, 16'h1234);
        drive(1'b0, R0, 16'hFFFF, R0, R0);
        chk("r0_next", 16'h0000, 16'h0000, 16'h0000, 16'h0000);

        // Bypass vs stored value.
        drive(1'b1, R2, 16'h00AA, R0, R0);
        drive(1'b1, R1, 16'h0101, R0, R0);
        drive(1'b1, R2, 16'h0055, R2, R1);
        chk("byp_r2", 16'h0055, 16'h0101, 16'h00AA, 16'h0101);
        drive(1'b0, R2, 16'h0000, R2, R1);
        chk("byp_after", 16'h0055, 16'h0101, 16'h0055, 16'h0101);
        drive(1'b1, R6, 16'h6666, R6, R6);
        chk("byp_both", 16'h6666, 16'h6666, 16'h0000, 16'h0000);

        // Full sweep.
        for (int k = 1; k < 8; k++) begin
            vk = 16'(k) * 16'h1111;
            drive(1'b1, 3'(k), vk, R0, R0);
        end
        drive(1'b0, R0, 16'h0000, R0, R0);
        for (int k = 1; k < 8; k++) begin
            vk = 16'(k) * 16'h1111;
            vm = 16'(8 - k) * 16'h1111;
            ReadAddr1 = 3'(k); ReadAddr2 = 3'(8 - k);
            chk("sweep", vk, vm, vk, vm);
        end

        // Disabled writes with moving data leave storage alone.
        for (int k = 1; k < 8; k++) begin
            drive(1'b0, 3'(k), 16'hDEAD ^ 16'(k), R3, R4);
        end
        drive(1'b1, 3'bxxx, 16'hDEAD, R3, R4);
        drive(1'b0, R0, 16'h0000, R3, R4);
        chk("no_write", 16'h3333, 16'h4444, 16'h3333, 16'h4444);

        // Mid-cycle async reset pulse of 3 ns.
        drive(1'b0, R0, 16'h0000, R7, R1);
        chk("pre_pulse", 16'h7777, 16'h1111, 16'h7777, 16'h1111);
        Reset_n = 1'b0;
        chk("pulse_low", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        #1;
        Reset_n = 1'b1;
        drive(1'b0, R0, 16'h0000, R7, R1);
        chk("pulse_after", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        drive(1'b1, R4, 16'h4A4A, R0, R0);
        drive(1'b0, R0, 16'h0000, R4, R3);
        chk("post_rst_wr", 16'h4A4A, 16'h0000, 16'h4A4A, 16'h0000);

        #2;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain got %0d pending want 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regjistrat_8x16.md
Name: regjistrat_8x16

Overview:
- Register file supplying the two ALU operand buses of the single-cycle datapath; the per-bit operation-select multiplexers inside the ALU consume its read data directly.
- Write-back comes from the ALU result, or from the data-memory mux for loads.
- Provides 8 general registers, 2 combinational read ports and 1 synchronous write port.
- R0 is hardwired to zero.
- An optional write-to-read bypass makes a register written this cycle visible on the read ports in the same cycle.

Parameters:
- DATA_W, 16, width of each register and of the data buses
- ADDR_W, 3, register address width; register count = 2**ADDR_W
- BYPASS, 1, 1 = forward write data to a read port whose address matches the write address; 0 = read returns the stored value only

Ports:
- Clock  input  1  system clock, rising edge active
- Reset_n  input  1  asynchronous active-low reset
- RegWrite  input  1  write enable, sampled on the rising edge of Clock
- WriteAddr  input  ADDR_W  destination register
- WriteData  input  DATA_W  value to write
- ReadAddr1  input  ADDR_W  source register for operand A
- ReadAddr2  input  ADDR_W  source register for operand B
- ReadData1  output  DATA_W  operand A to the ALU
- ReadData2  output  DATA_W  operand B to the ALU

Behaviour:
- Clock is the single clock. Reset_n is asynchronous and active-low.
- Reset:
  - On Reset_n low, every register clears to 0 immediately, without waiting for a clock edge.
  - Both ReadData outputs are therefore 0 during reset for any address. This holds with BYPASS=1 too: the bypass path is gated by Reset_n.
  - Registers stay cleared while Reset_n is low; writes are ignored.
  - On release, the first write takes effect at the first rising edge at which Reset_n is high.
- Write:
  - At the rising edge of Clock, if RegWrite=1 and WriteAddr!=0, then reg[WriteAddr] <= WriteData.
  - Register latency is 1 cycle: the new value appears on a non-bypassed read after the edge.
  - RegWrite=0 leaves all registers unchanged.
- R0:
  - A write to address 0 is silently discarded; no storage is required for R0.
  - A read of address 0 always returns 0, including when bypass matches.
- Read:
  - Purely combinational from ReadAddr and register contents; zero cycles of latency.
  - No registered outputs: this is a single-cycle datapath.
- Bypass (BYPASS=1):
  - If RegWrite=1, WriteAddr!=0 and ReadAddrN==WriteAddr, then ReadDataN = WriteData in the same cycle.
  - Otherwise ReadDataN = reg[ReadAddrN].
  - Both ports may bypass simultaneously when both read the write address.
- Simultaneous events:
  - Read and write of the same address with BYPASS=0 returns the old value until the edge.
  - Both read ports may address the same register.
- Unknowns: an X on WriteAddr with RegWrite=1 must not corrupt registers in simulation; the write is ignored when the address is not a known value.
- Reset asserted mid-cycle while RegWrite=1: reset wins and the write is lost.

Decomposition:
- Shared package/header holds:
  - the DATA_W and ADDR_W defaults;
  - the constant REG_ZERO = 0;
  - register-name constants R0..R7 used by the decoder and the testbench.
- One natural sub-module: regjistrat_lexo, a read port (address compare + bypass select + R0 force-zero). It is instantiated twice.
- Storage and write logic stay in the top module.

Test Plan:
- Reset: Reset_n=0 while RegWrite=1, WriteAddr=3, WriteData=16'hBEEF -> ReadData1 at address 3 is 16'h0000, both during reset and after release, with no clock needed to clear.
- Basic write/read: write R5=16'h1234; next cycle ReadAddr1=5, ReadAddr2=5 -> both outputs 16'h1234. Other registers still read 0.
- R0 protection: RegWrite=1, WriteAddr=0, WriteData=16'hFFFF; ReadAddr1=0 in the same and the next cycle -> 16'h0000, also with BYPASS=1.
- Bypass: BYPASS=1, R2 holds 16'h00AA; same cycle RegWrite=1, WriteAddr=2, WriteData=16'h0055, ReadAddr1=2, ReadAddr2=1 -> ReadData1=16'h0055, ReadData2=old R1. With BYPASS=0 -> ReadData1=16'h00AA before the edge and 16'h0055 after it.
- Full sweep: write Rk = k*16'h1111 for k=1..7 on consecutive cycles -> read back all pairs (k, 8-k) with the correct values. Then RegWrite=0 with changing WriteData -> no register changes.
- Async reset mid-run: with R1..R7 loaded, pulse Reset_n low for 3 ns between edges -> all reads return 0 immediately. A subsequent write to R4 works at the next edge.
